// File: rtl/pp_pipeline_accel_pkg.sv
// Shared helpers for the pipeline accelerator FIFOs: address sizing,
// parameter legality checks and the registered status-flag bundle.
package pp_pipeline_accel_pkg;

  typedef struct packed {
    logic empty_n;
    logic full_n;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // Status seen with zero words stored (almost_empty because 0 <= any AE level).
  localparam fifo_status_t FIFO_STATUS_RESET = '{
    empty_n:      1'b0,
    full_n:       1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && (depth <= 1024);
  endfunction

  function automatic bit af_thresh_ok(input int af_thresh, input int depth);
    return (af_thresh >= 1) && (af_thresh <= depth);
  endfunction

  function automatic bit ae_thresh_ok(input int ae_thresh, input int depth);
    return (ae_thresh >= 0) && (ae_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/pp_pipeline_accel_fifo_prog_shiftReg.sv
// Shift-register word store: every enabled write enters at index 0 and older
// words move up one slot; q reads any slot combinationally.
module pp_pipeline_accel_fifo_prog_shiftReg #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  ce,
  input  logic [ADDR_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem_reg[i] <= mem_reg[i-1];
      end
      mem_reg[0] <= data;
    end
  end

  assign q = mem_reg[a];

endmodule

// File: rtl/pp_pipeline_accel_fifo_prog.sv
// Show-ahead FIFO with programmable almost-full/almost-empty levels, flush,
// sticky overflow/underflow flags and an occupancy output.
module pp_pipeline_accel_fifo_prog
  import pp_pipeline_accel_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  input  logic                  if_flush,
  output logic                  if_almost_full,
  output logic                  if_almost_empty,
  output logic                  if_overflow,
  output logic                  if_underflow,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);

  generate
    if (!depth_ok(DEPTH) || (ADDR_WIDTH != clog2(DEPTH)) ||
        !af_thresh_ok(AF_THRESH, DEPTH) || !ae_thresh_ok(AE_THRESH, DEPTH)) begin : g_bad_params
      $error("pp_pipeline_accel_fifo_prog: illegal DEPTH/ADDR_WIDTH/AF_THRESH/AE_THRESH");
    end
  endgenerate

  localparam logic [ADDR_WIDTH:0] CAP      = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LEVEL = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [ADDR_WIDTH:0]   count_reg, count_next;
  fifo_status_t          status_reg, status_next;
  logic                  overflow_reg, overflow_next;
  logic                  underflow_reg, underflow_next;
  logic                  wr_en, rd_en;
  logic                  shift_en;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Accepted transfers are qualified by the registered flags, so a write into
  // a full FIFO is dropped even when a read frees a slot in the same cycle.
  assign wr_en = if_write & if_write_ce & status_reg.full_n;
  assign rd_en = if_read  & if_read_ce  & status_reg.empty_n;

  always_comb begin
    count_next = count_reg;
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    status_next              = FIFO_STATUS_RESET;
    status_next.empty_n      = (count_next != '0);
    status_next.full_n       = (count_next != CAP);
    status_next.almost_full  = (count_next >= AF_LEVEL);
    status_next.almost_empty = (count_next <= AE_LEVEL);
  end

  assign overflow_next  = overflow_reg  | (if_write & if_write_ce & ~status_reg.full_n);
  assign underflow_next = underflow_reg | (if_read  & if_read_ce  & ~status_reg.empty_n);

  always_ff @(posedge clk) begin
    if (reset || if_flush) begin
      count_reg     <= '0;
      status_reg    <= FIFO_STATUS_RESET;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      status_reg    <= status_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Oldest word sits at index count-1 because every write shifts the store.
  assign shift_en = wr_en & ~if_flush & ~reset;
  assign rd_addr  = (count_reg == '0) ? '0 : ADDR_WIDTH'(count_reg - 1'b1);

  pp_pipeline_accel_fifo_prog_shiftReg #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_store (
    .clk (clk),
    .data(if_din),
    .ce  (shift_en),
    .a   (rd_addr),
    .q   (if_dout)
  );

  assign if_empty_n        = status_reg.empty_n;
  assign if_full_n         = status_reg.full_n;
  assign if_almost_full    = status_reg.almost_full;
  assign if_almost_empty   = status_reg.almost_empty;
  assign if_overflow       = overflow_reg;
  assign if_underflow      = underflow_reg;
  assign if_num_data_valid = count_reg;
  assign if_fifo_cap       = CAP;

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_prog.sv
// Bench for pp_pipeline_accel_fifo_prog: directed vector table for the corner
// cases, then randomized traffic against a queue-based reference model.
module tb_pp_pipeline_accel_fifo_prog;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_write = 1'b0, if_write_ce = 1'b0;
  logic [DW-1:0] if_din = '0;
  logic          if_full_n;
  logic          if_read = 1'b0, if_read_ce = 1'b0;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
  logic          if_flush = 1'b0;
  logic          if_almost_full, if_almost_empty;
  logic          if_overflow, if_underflow;
  logic [AW:0]   if_num_data_valid;
  logic [AW:0]   if_fifo_cap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pp_pipeline_accel_fifo_prog #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .reset(reset),
    .if_write(if_write), .if_write_ce(if_write_ce), .if_din(if_din), .if_full_n(if_full_n),
    .if_read(if_read), .if_read_ce(if_read_ce), .if_dout(if_dout), .if_empty_n(if_empty_n),
    .if_flush(if_flush), .if_almost_full(if_almost_full), .if_almost_empty(if_almost_empty),
    .if_overflow(if_overflow), .if_underflow(if_underflow),
    .if_num_data_valid(if_num_data_valid), .if_fifo_cap(if_fifo_cap)
  );

  typedef struct {
    logic       rst, wr, wce, rd, rce, fl;
    logic [7:0] din;
    int         cnt;
    logic       en, fn, af, ae, ov, un;
    logic       dchk;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: plain queue plus sticky flags.
  logic [7:0] mq[$];
  bit         m_ovf, m_unf;

  function automatic void check1(string name, int step, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endfunction

  task automatic drive_cycle(input logic rst, wr, wce, rd, rce, fl, input logic [7:0] din);
    reset = rst; if_write = wr; if_write_ce = wce; if_read = rd; if_read_ce = rce;
    if_flush = fl; if_din = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int step, input int cnt, input logic en, fn, af, ae, ov, un,
                           input logic dchk, input logic [7:0] dout);
    $display("step %0d: rst=%0b wr=%0b/%0b rd=%0b/%0b fl=%0b din=%02h -> cnt=%0d en=%0b fn=%0b af=%0b ae=%0b ov=%0b un=%0b dout=%02h",
             step, reset, if_write, if_write_ce, if_read, if_read_ce, if_flush, if_din,
             if_num_data_valid, if_empty_n, if_full_n, if_almost_full, if_almost_empty,
             if_overflow, if_underflow, if_dout);
    check1("count",        step, int'(if_num_data_valid), cnt);
    check1("empty_n",      step, int'(if_empty_n),        int'(en));
    check1("full_n",       step, int'(if_full_n),         int'(fn));
    check1("almost_full",  step, int'(if_almost_full),    int'(af));
    check1("almost_empty", step, int'(if_almost_empty),   int'(ae));
    check1("overflow",     step, int'(if_overflow),       int'(ov));
    check1("underflow",    step, int'(if_underflow),      int'(un));
    if (dchk) check1("dout", step, int'(if_dout), int'(dout));
  endtask

  initial begin
    // rst wr wce rd rce fl din | cnt en fn af ae ov un dchk dout
    vecs.push_back('{1,0,0,0,0,0,8'h00, 0,0,1,0,1,0,0,0,8'h00});
    vecs.push_back('{0,1,1,0,0,0,8'h11, 1,1,1,0,1,0,0,1,8'h11});
    vecs.push_back('{0,1,1,0,0,0,8'h22, 2,1,1,0,0,0,0,1,8'h11});
    vecs.push_back('{0,1,1,0,0,0,8'h33, 3,1,1,1,0,0,0,1,8'h11});
    vecs.push_back('{0,1,1,0,0,0,8'h44, 4,1,0,1,0,0,0,1,8'h11});
    vecs.push_back('{0,0,0,1,1,0,8'h00, 3,1,1,1,0,0,0,1,8'h22});
    vecs.push_back('{0,0,0,1,1,0,8'h00, 2,1,1,0,0,0,0,1,8'h33});
    vecs.push_back('{0,0,0,1,1,0,8'h00, 1,1,1,0,1,0,0,1,8'h44});
    vecs.push_back('{0,0,0,1,1,0,8'h00, 0,0,1,0,1,0,0,0,8'h00});
    vecs.push_back('{0,1,1,0,0,0,8'hA0, 1,1,1,0,1,0,0,1,8'hA0});
    vecs.push_back('{0,1,1,0,0,0,8'hA1, 2,1,1,0,0,0,0,1,8'hA0});
    vecs.push_back('{0,1,1,1,1,0,8'hA2, 2,1,1,0,0,0,0,1,8'hA1});
    vecs.push_back('{0,0,0,1,1,0,8'h00, 1,1,1,0,1,0,0,1,8'hA2});
    vecs.push_back('{0,0,0,1,1,0,8'h00, 0,0,1,0,1,0,0,0,8'h00});
    vecs.push_back('{0,1,1,0,0,0,8'h01, 1,1,1,0,1,0,0,1,8'h01});
    vecs.push_back('{0,1,1,0,0,0,8'h02, 2,1,1,0,0,0,0,1,8'h01});
    vecs.push_back('{0,1,1,0,0,0,8'h03, 3,1,1,1,0,0,0,1,8'h01});
    vecs.push_back('{0,1,1,0,0,0,8'h04, 4,1,0,1,0,0,0,1,8'h01});
    vecs.push_back('{0,1,1,1,1,0,8'h55, 3,1,1,1,0,1,0,1,8'h02});
    vecs.push_back('{0,0,0,1,1,0,8'h00, 2,1,1,0,0,1,0,1,8'h03});
    vecs.push_back('{0,0,0,1,1,0,8'h00, 1,1,1,0,1,1,0,1,8'h04});
    vecs.push_back('{0,0,0,1,1,0,8'h00, 0,0,1,0,1,1,0,0,8'h00});
    vecs.push_back('{0,0,0,1,1,0,8'h00, 0,0,1,0,1,1,1,0,8'h00});
    vecs.push_back('{0,1,1,0,0,0,8'hB0, 1,1,1,0,1,1,1,1,8'hB0});
    vecs.push_back('{0,1,1,0,0,0,8'hB1, 2,1,1,0,0,1,1,1,8'hB0});
    vecs.push_back('{0,1,1,0,0,0,8'hB2, 3,1,1,1,0,1,1,1,8'hB0});
    vecs.push_back('{0,1,1,0,0,1,8'hB3, 0,0,1,0,1,0,0,0,8'h00});
    vecs.push_back('{0,1,0,0,0,0,8'h77, 0,0,1,0,1,0,0,0,8'h00});
    vecs.push_back('{0,0,0,1,0,0,8'h00, 0,0,1,0,1,0,0,0,8'h00});
    vecs.push_back('{0,1,1,0,0,0,8'hC0, 1,1,1,0,1,0,0,1,8'hC0});
    vecs.push_back('{0,1,1,0,0,0,8'hC1, 2,1,1,0,0,0,0,1,8'hC0});
    vecs.push_back('{0,1,0,0,0,0,8'hC2, 2,1,1,0,0,0,0,1,8'hC0});
    vecs.push_back('{1,1,1,0,0,1,8'hD0, 0,0,1,0,1,0,0,0,8'h00});
    vecs.push_back('{0,0,0,0,0,0,8'h00, 0,0,1,0,1,0,0,0,8'h00});

    for (int i = 0; i < vecs.size(); i++) begin
      drive_cycle(vecs[i].rst, vecs[i].wr, vecs[i].wce, vecs[i].rd, vecs[i].rce,
                  vecs[i].fl, vecs[i].din);
      check_all(i, vecs[i].cnt, vecs[i].en, vecs[i].fn, vecs[i].af, vecs[i].ae,
                vecs[i].ov, vecs[i].un, vecs[i].dchk, vecs[i].dout);
    end
    check1("fifo_cap", 0, int'(if_fifo_cap), DEPTH);

    // Randomized traffic; the model starts empty with clear flags, as the table leaves it.
    mq.delete();
    m_ovf = 0;
    m_unf = 0;
    for (int n = 0; n < 1500; n++) begin
      logic r_rst, r_wr, r_wce, r_rd, r_rce, r_fl;
      logic [7:0] r_din;
      int sz;
      r_rst = ($urandom_range(0, 99) == 0);
      r_fl  = ($urandom_range(0, 39) == 0);
      r_wr  = ($urandom_range(0, 99) < 60);
      r_wce = ($urandom_range(0, 9) != 0);
      r_rd  = ($urandom_range(0, 99) < 50);
      r_rce = ($urandom_range(0, 9) != 0);
      r_din = 8'($urandom);
      sz = mq.size();
      if (r_rst || r_fl) begin
        mq.delete();
        m_ovf = 0;
        m_unf = 0;
      end else begin
        if (r_wr && r_wce && sz == DEPTH) m_ovf = 1;
        if (r_rd && r_rce && sz == 0) m_unf = 1;
        if (r_rd && r_rce && sz != 0) void'(mq.pop_front());
        if (r_wr && r_wce && sz != DEPTH) mq.push_back(r_din);
      end
      drive_cycle(r_rst, r_wr, r_wce, r_rd, r_rce, r_fl, r_din);
      sz = mq.size();
      check_all(1000 + n, sz, sz != 0, sz != DEPTH, sz >= AF, sz <= AE, m_ovf, m_unf,
                sz != 0, (sz != 0) ? mq[0] : 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
